// File: rtl/rg8_load_arb_if.sv
// rg8_load_arb_if -- bundle between two load requesters, the arbiter and the
// shared dual-source register it feeds.
//   Requester A : req_a, dat_a[7:0] -> ack_a
//   Requester B : req_b, dat_b[7:0] -> ack_b
//   Control     : stall (freezes new grants)
//   Register    : lda, dia[7:0], ldb, dib[7:0], busy, loads[7:0]
// modport slave  : the arbiter's view
// modport master : the view of the requesters / register environment
interface rg8_load_arb_if;
  logic       req_a;
  logic [7:0] dat_a;
  logic       ack_a;
  logic       req_b;
  logic [7:0] dat_b;
  logic       ack_b;
  logic       stall;
  logic       lda;
  logic [7:0] dia;
  logic       ldb;
  logic [7:0] dib;
  logic       busy;
  logic [7:0] loads;

  modport slave (
    input  req_a, dat_a, req_b, dat_b, stall,
    output ack_a, ack_b, lda, dia, ldb, dib, busy, loads
  );

  modport master (
    output req_a, dat_a, req_b, dat_b, stall,
    input  ack_a, ack_b, lda, dia, ldb, dib, busy, loads
  );
endinterface

// File: rtl/rg8_load_arb.sv
// rg8_load_arb -- two-requester load arbiter for a shared dual-source
// register. A has priority over B, but after STARVE_LIM consecutive A grants
// taken while B was waiting, B is forced through. Every grant produces a
// one-cycle load strobe plus ack in the cycle after the sampling edge.
// Ports:
//   clk   : single clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : rg8_load_arb_if.slave (requests/data in, strobes/acks/data out,
//           stall in, busy and grant counter out)
// Parameter:
//   STARVE_LIM : max consecutive A grants while B pends (1..15)
module rg8_load_arb #(
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  rg8_load_arb_if.slave   bus
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  // One-hot-style encoding so the strobes come straight off state flops.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD_A = 2'b01,
    LOAD_B = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [7:0] dia_q, dib_q, loads_q;
  logic       grant_a, grant_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: pick the winner from requests seen at this edge
  always_comb begin
    state_d  = IDLE;
    starve_d = starve_q;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    if (!bus.stall) begin
      if (bus.req_a && bus.req_b) begin
        if (starve_q == LIM) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else if (bus.req_a) begin
        grant_a = 1'b1;
      end else if (bus.req_b) begin
        grant_b = 1'b1;
      end
      // The counter only measures an unbroken run of A wins over a waiting B;
      // a stalled edge leaves it untouched.
      if (grant_b || !bus.req_b) begin
        starve_d = 4'd0;
      end else if (grant_a) begin
        starve_d = starve_q + 4'd1;
      end
      if (grant_a) begin
        state_d = LOAD_A;
      end else if (grant_b) begin
        state_d = LOAD_B;
      end
    end
  end

  // Captured data, grant counter and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dia_q    <= 8'h00;
      dib_q    <= 8'h00;
      loads_q  <= 8'h00;
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
      if (grant_a) begin
        dia_q <= bus.dat_a;
      end
      if (grant_b) begin
        dib_q <= bus.dat_b;
      end
      if (grant_a || grant_b) begin
        loads_q <= loads_q + 8'd1;
      end
    end
  end

  // Outputs: pure decode of registered state, no input paths
  always_comb begin
    bus.lda   = state_q[0];
    bus.ldb   = state_q[1];
    bus.ack_a = state_q[0];
    bus.ack_b = state_q[1];
    bus.busy  = state_q[0] | state_q[1];
    bus.dia   = dia_q;
    bus.dib   = dib_q;
    bus.loads = loads_q;
  end

endmodule

// File: tb/tb_rg8_load_arb.sv
// tb_rg8_load_arb -- directed bench for rg8_load_arb (STARVE_LIM=3).
// Stimulus pushes the expected grant into a queue before the sampling edge;
// a monitor pops it whenever a strobe appears and compares.
module tb_rg8_load_arb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rg8_load_arb_if bus ();

  rg8_load_arb #(.STARVE_LIM(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         is_b;
    logic [7:0] d;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit b, input logic [7:0] d, input logic [7:0] c);
    exp_t e;
    e.is_b = b;
    e.d    = d;
    e.cnt  = c;
    q.push_back(e);
  endtask

  // Advance to 1 time unit after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.lda || bus.ldb) begin
          chk("strobe_excl", 32'(bus.lda & bus.ldb), 32'd0);
          if (q.size() == 0) begin
            chk("unexpected_grant", 32'({bus.lda, bus.ldb}), 32'd0);
          end else begin
            mon_e = q.pop_front();
            chk("lda",   32'(bus.lda),   32'(!mon_e.is_b));
            chk("ldb",   32'(bus.ldb),   32'(mon_e.is_b));
            chk("ack_a", 32'(bus.ack_a), 32'(!mon_e.is_b));
            chk("ack_b", 32'(bus.ack_b), 32'(mon_e.is_b));
            chk("busy",  32'(bus.busy),  32'd1);
            chk("data",  32'(mon_e.is_b ? bus.dib : bus.dia), 32'(mon_e.d));
            chk("loads", 32'(bus.loads), 32'(mon_e.cnt));
          end
        end else begin
          chk("idle_acks", 32'({bus.ack_a, bus.ack_b, bus.busy}), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_a = 1'b0;
    bus.dat_a = 8'h00;
    bus.req_b = 1'b0;
    bus.dat_b = 8'h00;
    bus.stall = 1'b0;
    #12;
    // Reset state
    chk("rst_lda",   32'(bus.lda),   32'd0);
    chk("rst_ldb",   32'(bus.ldb),   32'd0);
    chk("rst_ack_a", 32'(bus.ack_a), 32'd0);
    chk("rst_ack_b", 32'(bus.ack_b), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_dia",   32'(bus.dia),   32'h00);
    chk("rst_dib",   32'(bus.dib),   32'h00);
    chk("rst_loads", 32'(bus.loads), 32'h00);

    // Single A load at the very first edge after reset release
    @(negedge clk);
    rst_n     = 1'b1;
    bus.req_a = 1'b1;
    bus.dat_a = 8'h5A;
    push(1'b0, 8'h5A, 8'd1);
    step();
    bus.req_a = 1'b0;
    bus.dat_a = 8'hFF;
    step();
    #3;
    chk("idle_lda",  32'(bus.lda), 32'd0);
    chk("hold_dia",  32'(bus.dia), 32'h5A);

    // Both requesting continuously: A,A,A,B,A,A,A,B
    step();
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.dat_a = 8'h10 + 8'(i);
      bus.dat_b = 8'h20 + 8'(i);
      if (i == 3 || i == 7) push(1'b1, 8'h20 + 8'(i), 8'd2 + 8'(i));
      else                  push(1'b0, 8'h10 + 8'(i), 8'd2 + 8'(i));
      step();
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    step();

    // B pending through 4 stalled edges, granted once stall drops
    bus.req_b = 1'b1;
    bus.dat_b = 8'hC3;
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("stall_ldb",   32'(bus.ldb),   32'd0);
    chk("stall_loads", 32'(bus.loads), 32'd9);
    bus.stall = 1'b0;
    push(1'b1, 8'hC3, 8'd10);
    step();
    bus.req_b = 1'b0;
    step();

    // Request raised and withdrawn between edges
    bus.req_a = 1'b1;
    bus.dat_a = 8'h99;
    #2;
    bus.req_a = 1'b0;
    step();
    step();
    chk("glitch_lda",   32'(bus.lda),   32'd0);
    chk("glitch_loads", 32'(bus.loads), 32'd10);

    // Back-to-back B grants from a held request
    bus.req_b = 1'b1;
    bus.dat_b = 8'h44;
    push(1'b1, 8'h44, 8'd11);
    step();
    bus.dat_b = 8'h45;
    push(1'b1, 8'h45, 8'd12);
    step();
    bus.req_b = 1'b0;
    step();

    // Counter wrap: reset, 255 grants to reach 255, one more wraps to 0
    rst_n = 1'b0;
    #1;
    chk("rst2_loads", 32'(bus.loads), 32'h00);
    chk("rst2_dib",   32'(bus.dib),   32'h00);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.req_a = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      bus.dat_a = 8'(i);
      push(1'b0, 8'(i), 8'(i));
      step();
    end
    bus.req_a = 1'b0;
    step();
    chk("wrap_loads", 32'(bus.loads), 32'h00);

    // Reset in the middle of a B load aborts it asynchronously
    bus.req_b = 1'b1;
    bus.dat_b = 8'h77;
    step();
    bus.req_b = 1'b0;
    chk("pre_abort_ldb",   32'(bus.ldb),   32'd1);
    chk("pre_abort_loads", 32'(bus.loads), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ldb",   32'(bus.ldb),   32'd0);
    chk("abort_ack_b", 32'(bus.ack_b), 32'd0);
    chk("abort_busy",  32'(bus.busy),  32'd0);
    chk("abort_lda",   32'(bus.lda),   32'd0);
    chk("abort_loads", 32'(bus.loads), 32'h00);
    chk("abort_dib",   32'(bus.dib),   32'h00);
    chk("abort_dia",   32'(bus.dia),   32'h00);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("post_abort_loads", 32'(bus.loads), 32'h00);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
